// File: rtl/fifo18k_rd_stream_adapter.sv
`timescale 1ns/1ps
// Read-side adapter for a TDP18K FIFO in FIFO mode: issues REN against buffer credit,
// realigns the RAM read latency, masks by read width and serves a FWFT valid/ready stream.
module fifo18k_rd_stream_adapter #(
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic        CLK_i,
  input  logic        RESET_i,
  input  logic        FLUSH_i,
  input  logic [2:0]  RMODE_i,
  input  logic        EMPTY_i,
  input  logic        EPO_i,
  input  logic [17:0] RDATA_i,
  output logic        REN_o,
  output logic        M_VALID_o,
  output logic [17:0] M_DATA_o,
  input  logic        M_READY_i,
  output logic [2:0]  LEVEL_o,
  output logic        ERR_o
);

  localparam int DATA_W = 18;
  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + RD_LATENCY + 2) + 1;
  localparam logic [2:0] LVL_FULL = 3'(BUF_DEPTH);

  function automatic logic [DATA_W-1:0] width_mask(input logic [2:0] mode,
                                                   input logic [DATA_W-1:0] d);
    case (mode)
      3'b010:  width_mask = d;
      3'b100:  width_mask = d & 18'h100FF;
      3'b001:  width_mask = d & 18'h0000F;
      3'b011:  width_mask = d & 18'h00003;
      3'b101:  width_mask = d & 18'h00001;
      default: width_mask = '0;
    endcase
  endfunction

  function automatic logic mode_illegal(input logic [2:0] mode);
    case (mode)
      3'b010, 3'b100, 3'b001, 3'b011, 3'b101: mode_illegal = 1'b0;
      default:                                mode_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] inflight_cnt(input logic [RD_LATENCY-1:0] v);
    inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight_cnt = inflight_cnt + CNT_W'(v[i]);
  endfunction

  logic [RD_LATENCY-1:0] vld_p;
  logic [RD_LATENCY-1:0] vld_nxt;
  logic [DATA_W-1:0]     buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [2:0]            level;
  logic                  err;
  logic [DATA_W-1:0]     m_data;

  logic                  ren;
  logic                  pop;
  logic                  capture;
  logic                  cap_ok;
  logic                  cap_ovf;
  logic                  cap_bad;
  logic [DATA_W-1:0]     cap_data;
  logic [CNT_W-1:0]      used;
  logic [CNT_W-1:0]      room;

  // ---- issue: credit counts buffered words plus reads still in the RAM pipe
  assign pop      = M_VALID_o & M_READY_i;
  assign used     = CNT_W'(level) + inflight_cnt(vld_p);
  assign room     = CNT_W'(BUF_DEPTH) + CNT_W'(pop);
  // vld_p[0] is REN from last cycle; flags lag a read by one cycle, so EPO blocks a second read
  assign ren      = ~EMPTY_i & (used < room) & ~(EPO_i & vld_p[0]) & ~FLUSH_i & ~RESET_i;

  always_comb begin
    vld_nxt    = '0;
    vld_nxt[0] = ren;
    for (int i = 1; i < RD_LATENCY; i++) vld_nxt[i] = vld_p[i-1];
  end

  // ---- return: tail of the valid pipe marks RDATA_i as a live word
  assign capture    = vld_p[RD_LATENCY-1];
  assign cap_bad    = mode_illegal(RMODE_i);
  assign cap_data   = width_mask(RMODE_i, RDATA_i);
  assign cap_ovf    = capture & (level == LVL_FULL);
  assign cap_ok     = capture & ~cap_ovf;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);

  always_ff @(posedge CLK_i) begin
    if (RESET_i) begin
      vld_p  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      err    <= 1'b0;
      m_data <= '0;
    end else begin
      if (capture & (cap_bad | cap_ovf)) err <= 1'b1;
      if (FLUSH_i) begin
        vld_p  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        vld_p  <= vld_nxt;
        rd_ptr <= rd_ptr_nxt;
        level  <= level + 3'(cap_ok) - 3'(pop);
        if (cap_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        // ---- output: register the head as it will be after this edge, bypassing a same-cycle write
        if (cap_ok && (wr_ptr == rd_ptr_nxt)) m_data <= cap_data;
        else                                  m_data <= buf_mem[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge CLK_i) begin
    if (cap_ok) buf_mem[wr_ptr] <= cap_data;
  end

  assign REN_o     = ren;
  assign M_VALID_o = (level != 3'd0);
  assign M_DATA_o  = m_data;
  assign LEVEL_o   = level;
  assign ERR_o     = err;

endmodule

// File: tb/tb_fifo18k_rd_stream_adapter.sv
`timescale 1ns/1ps
// Directed bench: two adapters (read latency 1 and 2) each fed by a small FIFO model
// whose EMPTY/EPO flags lag a read by one cycle, as the TDP18K flags do.
module tb_fifo18k_rd_stream_adapter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ren   [2];
  logic        vld   [2];
  logic        ready [2];
  logic        empty [2];
  logic        epo   [2];
  logic        err   [2];
  logic [17:0] rdata [2];
  logic [17:0] mdata [2];
  logic [2:0]  level [2];
  logic [2:0]  rmode [2];

  logic [17:0] fmem [2][4096];
  int          wcnt [2];

  logic [17:0] recv0[$];
  logic [17:0] recv1[$];
  int          viol0 = 0, viol1 = 0, rencnt0 = 0;
  int          maxlvl0 = 0, maxlvl1 = 0;
  int          n_tests = 0, n_fail = 0;

  fifo18k_rd_stream_adapter #(.RD_LATENCY(1), .BUF_DEPTH(4)) dut0 (
    .CLK_i(clk), .RESET_i(rst), .FLUSH_i(flush), .RMODE_i(rmode[0]),
    .EMPTY_i(empty[0]), .EPO_i(epo[0]), .RDATA_i(rdata[0]), .REN_o(ren[0]),
    .M_VALID_o(vld[0]), .M_DATA_o(mdata[0]), .M_READY_i(ready[0]),
    .LEVEL_o(level[0]), .ERR_o(err[0]));

  fifo18k_rd_stream_adapter #(.RD_LATENCY(2), .BUF_DEPTH(4)) dut1 (
    .CLK_i(clk), .RESET_i(rst), .FLUSH_i(flush), .RMODE_i(rmode[1]),
    .EMPTY_i(empty[1]), .EPO_i(epo[1]), .RDATA_i(rdata[1]), .REN_o(ren[1]),
    .M_VALID_o(vld[1]), .M_DATA_o(mdata[1]), .M_READY_i(ready[1]),
    .LEVEL_o(level[1]), .ERR_o(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_model
    int          rcnt = 0;
    int          cnt_d = 0;
    int          underflow = 0;
    logic [17:0] d1 = '0;
    logic [17:0] d2 = '0;
    always @(posedge clk) begin
      cnt_d <= wcnt[g] - rcnt;
      if (ren[g]) begin
        if (wcnt[g] == rcnt) underflow <= underflow + 1;
        else begin
          d1   <= fmem[g][rcnt];
          rcnt <= rcnt + 1;
        end
      end
      d2 <= d1;
    end
    assign empty[g] = (cnt_d == 0);
    assign epo[g]   = (cnt_d == 1);
    assign rdata[g] = (g == 0) ? d1 : d2;
  end

  always @(negedge clk) begin
    if (vld[0] && ready[0]) recv0.push_back(mdata[0]);
    if (vld[1] && ready[1]) recv1.push_back(mdata[1]);
    if (ren[0] && empty[0]) viol0++;
    if (ren[1] && empty[1]) viol1++;
    if (ren[0]) rencnt0++;
    if (int'(level[0]) > maxlvl0) maxlvl0 = int'(level[0]);
    if (int'(level[1]) > maxlvl1) maxlvl1 = int'(level[1]);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int k, input logic [17:0] w);
    fmem[k][wcnt[k]] = w;
    wcnt[k] = wcnt[k] + 1;
  endtask

  logic [17:0] t1w [3];
  logic [2:0]  t3m [6];
  logic [17:0] t3d [6];
  logic [17:0] t3e [6];
  logic [5:0]  renmask, vmask;
  logic [17:0] held;
  int          base, rb, bad;

  initial begin
    t1w = '{18'h00A01, 18'h2B5C3, 18'h1FFFE};
    t3m = '{3'b010, 3'b100, 3'b101, 3'b001, 3'b011, 3'b111};
    t3d = '{18'h2ABCD, 18'h3FFFF, 18'h3FFFF, 18'h2ABCD, 18'h3FFFF, 18'h3FFFF};
    t3e = '{18'h2ABCD, 18'h100FF, 18'h00001, 18'h0000D, 18'h00003, 18'h00000};
    wcnt[0] = 0; wcnt[1] = 0;
    rst = 1'b1; flush = 1'b0;
    ready[0] = 1'b0; ready[1] = 1'b0;
    rmode[0] = 3'b010; rmode[1] = 3'b010;
    step(3);
    check("rst_ren",   32'(ren[0]),   0);
    check("rst_valid", 32'(vld[0]),   0);
    check("rst_data",  32'(mdata[0]), 0);
    check("rst_level", 32'(level[0]), 0);
    check("rst_err",   32'(err[0]),   0);
    rst = 1'b0;
    step(2);

    // three words, no backpressure: REN in cycles 0..2, valid in cycles 2..4
    ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) push(0, t1w[i]);
    renmask = '0; vmask = '0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      renmask[i] = ren[0];
      vmask[i]   = vld[0];
      if (i >= 2 && i <= 4) check("t1_data", 32'(mdata[0]), 32'(t1w[i-2]));
    end
    check("t1_ren_cycles",   32'(renmask), 32'h07);
    check("t1_valid_cycles", 32'(vmask),   32'h1C);

    // backpressure: ten words, sink stalled
    ready[0] = 1'b0;
    base = recv0.size();
    rb = rencnt0;
    for (int i = 0; i < 10; i++) push(0, 18'h20000 | 18'(i));
    step(12);
    check("t2_ren_pulses", 32'(rencnt0 - rb), 4);
    check("t2_ren_idle",   32'(ren[0]),   0);
    check("t2_level",      32'(level[0]), 4);
    check("t2_valid",      32'(vld[0]),   1);
    check("t2_head",       32'(mdata[0]), 32'h20000);
    held = mdata[0];
    step(3);
    check("t2_head_stable", 32'(mdata[0]), 32'(held));
    ready[0] = 1'b1;
    for (int c = 0; c < 40 && (recv0.size() - base) < 10; c++) step(1);
    step(4);
    check("t2_count", 32'(recv0.size() - base), 10);
    for (int i = 0; i < 10 && base + i < recv0.size(); i++)
      check("t2_order", 32'(recv0[base+i]), 32'h20000 | 32'(i));

    // read-width masking, illegal code last
    for (int m = 0; m < 6; m++) begin
      if (m == 5) check("t3_err_before", 32'(err[0]), 0);
      rmode[0] = t3m[m];
      base = recv0.size();
      push(0, t3d[m]);
      for (int c = 0; c < 20 && recv0.size() == base; c++) step(1);
      check("t3_count", 32'(recv0.size() - base), 1);
      if (recv0.size() > base) check("t3_mask", 32'(recv0[base]), 32'(t3e[m]));
    end
    check("t3_err_set", 32'(err[0]), 1);
    rmode[0] = 3'b010;
    step(5);
    check("t3_err_sticky", 32'(err[0]), 1);

    // flush with three buffered words and one read in flight
    ready[0] = 1'b0;
    base = recv0.size();
    for (int i = 0; i < 8; i++) push(0, 18'h30000 | 18'(i));
    for (int c = 0; c < 20 && level[0] != 3'd3; c++) step(1);
    check("t5_level3", 32'(level[0]), 3);
    flush = 1'b1;
    #1;
    check("t5_ren_flush", 32'(ren[0]), 0);
    step(1);
    flush = 1'b0;
    check("t5_level_after", 32'(level[0]), 0);
    check("t5_valid_after", 32'(vld[0]),   0);
    check("t5_err_kept",    32'(err[0]),   1);
    ready[0] = 1'b1;
    for (int c = 0; c < 40 && (recv0.size() - base) < 4; c++) step(1);
    step(5);
    check("t5_count", 32'(recv0.size() - base), 4);
    for (int i = 0; i < 4 && base + i < recv0.size(); i++)
      check("t5_order", 32'(recv0[base+i]), 32'h30004 + 32'(i));

    // reset mid-stream: first three popped words are discarded
    ready[0] = 1'b0;
    base = recv0.size();
    for (int i = 0; i < 6; i++) push(0, 18'h0C000 | 18'(i));
    for (int c = 0; c < 20 && level[0] != 3'd2; c++) step(1);
    check("t6_valid_before", 32'(vld[0]), 1);
    rst = 1'b1;
    #1;
    check("t6_ren_in_rst", 32'(ren[0]), 0);
    step(1);
    check("t6_ren",   32'(ren[0]),   0);
    check("t6_valid", 32'(vld[0]),   0);
    check("t6_data",  32'(mdata[0]), 0);
    check("t6_level", 32'(level[0]), 0);
    check("t6_err",   32'(err[0]),   0);
    rst = 1'b0;
    #1;
    check("t6_ren_resume", 32'(ren[0]), 1);
    ready[0] = 1'b1;
    for (int c = 0; c < 40 && (recv0.size() - base) < 3; c++) step(1);
    step(5);
    check("t6_count", 32'(recv0.size() - base), 3);
    for (int i = 0; i < 3 && base + i < recv0.size(); i++)
      check("t6_order", 32'(recv0[base+i]), 32'h0C003 + 32'(i));

    // read latency 2, 1000 random words, random sink stalls
    for (int i = 0; i < 1000; i++) push(1, 18'($urandom));
    for (int c = 0; c < 20000 && recv1.size() < 1000; c++) begin
      ready[1] = ($urandom_range(0, 2) != 0);
      step(1);
    end
    ready[1] = 1'b1;
    step(10);
    check("t4_count", 32'(recv1.size()), 1000);
    bad = 0;
    for (int i = 0; i < 1000; i++)
      if (i >= recv1.size() || recv1[i] !== fmem[1][i]) bad++;
    check("t4_order_errs",  32'(bad), 0);
    check("t4_err",         32'(err[1]), 0);
    check("t4_level_max_ok", 32'(maxlvl1 <= 4), 1);
    check("t4_ren_on_empty", 32'(viol1), 0);
    check("t4_underflow",    32'(g_model[1].underflow), 0);
    check("t4_level_end",    32'(level[1]), 0);
    check("all_ren_on_empty0", 32'(viol0), 0);
    check("all_underflow0",    32'(g_model[0].underflow), 0);
    check("all_level_max0",    32'(maxlvl0 <= 4), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
